// File: rtl/gpio_test_seq_if.sv
// Wishbone master bus bundle between the GPIO test sequencer and the GPIO test slave.
// 16-bit data, byte addressing, classic single-access handshake.
interface gpio_test_seq_if;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [1:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [15:0] wbm_dat_o;
   logic [15:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/gpio_test_seq.sv
// GPIO loopback test sequencer: enables outputs, writes four patterns, reads them back
// through the input registers under a width mask, then disables outputs and reports.
module gpio_test_seq #(
   parameter int unsigned GPIO_COUNT = 80,
   parameter logic [31:0] BASE_ADR   = 32'h0,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_n_i,
   input  logic            start_i,
   gpio_test_seq_if.master wbm,
   output logic            busy_o,
   output logic            done_o,
   output logic            pass_o,
   output logic            timeout_o,
   output logic [7:0]      fail_word_o,
   output logic [1:0]      fail_pat_o
);

   localparam int unsigned Words    = (GPIO_COUNT + 15) / 16;
   localparam int unsigned Rem      = GPIO_COUNT % 16;
   localparam logic [15:0] LastMask = (Rem == 0) ? 16'hFFFF : 16'((32'd1 << Rem) - 32'd1);
   localparam logic [7:0]  LastWord = 8'(Words - 1);
   localparam int unsigned TmoW     = $clog2(TIMEOUT + 2);
   localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT);

   typedef enum logic [2:0] {StIdle, StOeOn, StWrDout, StRdDin, StOeOff, StFinish} state_e;

   state_e          state_q;
   logic            cyc_q, we_q, pass_pend_q;
   logic [31:0]     adr_q;
   logic [15:0]     dat_q;
   logic [7:0]      word_q;
   logic [1:0]      pat_q;
   logic [TmoW-1:0] tmo_q;

   logic [15:0] pat_val, mask, rd_diff, acc_dat;
   logic [31:0] acc_adr, acc_off;
   logic        acc_we, last_word;

   always_comb begin
      case (pat_q)
         2'd0:    pat_val = 16'h0000;
         2'd1:    pat_val = 16'hFFFF;
         2'd2:    pat_val = 16'h5555;
         default: pat_val = 16'hAAAA;
      endcase
      last_word = (word_q == LastWord);
      mask      = last_word ? LastMask : 16'hFFFF;
      rd_diff   = (wbm.wbm_dat_i ^ pat_val) & mask;
      acc_we    = 1'b1;
      acc_dat   = 16'h0000;
      acc_off   = 32'h0;
      case (state_q)
         StOeOn: begin
            acc_off = 32'h40;
            acc_dat = 16'hFFFF;
         end
         StWrDout: begin
            acc_off = 32'h20;
            acc_dat = pat_val;
         end
         StRdDin:  acc_we  = 1'b0;
         StOeOff:  acc_off = 32'h40;
         default:  ;
      endcase
      acc_adr = BASE_ADR + acc_off + {23'h0, word_q, 1'b0};
   end

   // Bus states share one access engine: launch when idle, then wait for ack or timeout.
   // Dropping cyc on ack guarantees the one idle cycle before the next launch.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q     <= StIdle;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= 32'h0;
         dat_q       <= 16'h0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         timeout_o   <= 1'b0;
         fail_word_o <= 8'h0;
         fail_pat_o  <= 2'd0;
         pass_pend_q <= 1'b0;
         word_q      <= 8'h0;
         pat_q       <= 2'd0;
         tmo_q       <= '0;
      end else begin
         done_o <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_q     <= StOeOn;
                  busy_o      <= 1'b1;
                  pass_o      <= 1'b0;
                  timeout_o   <= 1'b0;
                  fail_word_o <= 8'h0;
                  fail_pat_o  <= 2'd0;
                  pass_pend_q <= 1'b0;
                  word_q      <= 8'h0;
                  pat_q       <= 2'd0;
               end
            end
            StOeOn, StWrDout, StRdDin, StOeOff: begin
               if (!cyc_q) begin
                  cyc_q <= 1'b1;
                  we_q  <= acc_we;
                  adr_q <= acc_adr;
                  dat_q <= acc_dat;
                  tmo_q <= '0;
               end else if (wbm.wbm_ack_i) begin
                  cyc_q  <= 1'b0;
                  we_q   <= 1'b0;
                  word_q <= last_word ? 8'h0 : word_q + 8'd1;
                  case (state_q)
                     StOeOn:   if (last_word) state_q <= StWrDout;
                     StWrDout: if (last_word) state_q <= StRdDin;
                     StRdDin: begin
                        if (rd_diff != 16'h0) begin
                           fail_word_o <= word_q;
                           fail_pat_o  <= pat_q;
                           word_q      <= 8'h0;
                           state_q     <= StOeOff;
                        end else if (last_word) begin
                           if (pat_q == 2'd3) begin
                              pass_pend_q <= 1'b1;
                              state_q     <= StOeOff;
                           end else begin
                              pat_q   <= pat_q + 2'd1;
                              state_q <= StWrDout;
                           end
                        end
                     end
                     default:  if (last_word) state_q <= StFinish;
                  endcase
               end else if (tmo_q == TmoMax) begin
                  cyc_q       <= 1'b0;
                  we_q        <= 1'b0;
                  timeout_o   <= 1'b1;
                  pass_pend_q <= 1'b0;
                  state_q     <= StFinish;
               end else begin
                  tmo_q <= tmo_q + TmoW'(1);
               end
            end
            StFinish: begin
               done_o  <= 1'b1;
               pass_o  <= pass_pend_q;
               busy_o  <= 1'b0;
               word_q  <= 8'h0;
               pat_q   <= 2'd0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign wbm.wbm_cyc_o = cyc_q;
   assign wbm.wbm_stb_o = cyc_q;
   assign wbm.wbm_we_o  = we_q;
   assign wbm.wbm_sel_o = 2'b11;
   assign wbm.wbm_adr_o = adr_q;
   assign wbm.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_gpio_test_seq.sv
// Bench for gpio_test_seq: loopback slave models, expected-access scoreboard,
// fault injection (stuck bit, masked garbage, missing ack, mid-run reset).
module tb_gpio_test_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   gpio_test_seq_if a_if ();
   gpio_test_seq_if b_if ();

   logic       busy_a, done_a, pass_a, tmo_a, busy_b, done_b, pass_b, tmo_b;
   logic [7:0] fw_a, fw_b;
   logic [1:0] fp_a, fp_b;

   gpio_test_seq #(.GPIO_COUNT(80), .BASE_ADR(32'h0), .TIMEOUT(255)) dut_a (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start_a), .wbm(a_if.master),
      .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .timeout_o(tmo_a),
      .fail_word_o(fw_a), .fail_pat_o(fp_a)
   );

   gpio_test_seq #(.GPIO_COUNT(72), .BASE_ADR(32'h0), .TIMEOUT(255)) dut_b (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start_b), .wbm(b_if.master),
      .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .timeout_o(tmo_b),
      .fail_word_o(fw_b), .fail_pat_o(fp_b)
   );

   // Slave A: loopback, ack one cycle after strobe; optional stuck bit / missing ack.
   logic [15:0] dout_a [16];
   logic [15:0] rd_a;
   logic s_ack_a = 1'b0, spur_ack = 1'b0, stuck = 1'b0, noack = 1'b0;
   assign a_if.wbm_ack_i = s_ack_a | spur_ack;
   assign a_if.wbm_dat_i = rd_a;
   always @(posedge clk) begin
      s_ack_a <= 1'b0;
      if (a_if.wbm_cyc_o && a_if.wbm_stb_o && !s_ack_a &&
          !(noack && a_if.wbm_we_o && a_if.wbm_adr_o == 32'h44)) begin
         s_ack_a <= 1'b1;
         if (a_if.wbm_we_o && a_if.wbm_adr_o[6:5] == 2'b01)
            dout_a[a_if.wbm_adr_o[4:1]] <= a_if.wbm_dat_o;
      end
   end
   always_comb begin
      rd_a = dout_a[a_if.wbm_adr_o[4:1]];
      if (stuck && a_if.wbm_adr_o[4:1] == 4'd2) rd_a[0] = 1'b0;
   end

   // Slave B: loopback, but word 4 upper byte returns garbage.
   logic [15:0] dout_b [16];
   logic [15:0] rd_b;
   logic s_ack_b = 1'b0;
   assign b_if.wbm_ack_i = s_ack_b;
   assign b_if.wbm_dat_i = rd_b;
   always @(posedge clk) begin
      s_ack_b <= 1'b0;
      if (b_if.wbm_cyc_o && b_if.wbm_stb_o && !s_ack_b) begin
         s_ack_b <= 1'b1;
         if (b_if.wbm_we_o && b_if.wbm_adr_o[6:5] == 2'b01)
            dout_b[b_if.wbm_adr_o[4:1]] <= b_if.wbm_dat_o;
      end
   end
   always_comb begin
      rd_b = dout_b[b_if.wbm_adr_o[4:1]];
      if (b_if.wbm_adr_o[4:1] == 4'd4) rd_b[15:8] = ~rd_b[15:8];
   end

   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [15:0] dat;
   } acc_t;
   acc_t exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_acc(input bit we, input int adr, input logic [15:0] dat);
      acc_t a;
      a.we  = we;
      a.adr = 32'(adr);
      a.dat = dat;
      exp_q.push_back(a);
   endtask

   // fw/fp: first mismatching word/pattern (-1 = none); stall_oe: OE word never acked.
   task automatic build_expected(input int fw, input int fp, input int stall_oe);
      logic [15:0] pats [4];
      bit stop = 0;
      pats[0] = 16'h0000; pats[1] = 16'hFFFF; pats[2] = 16'h5555; pats[3] = 16'hAAAA;
      for (int k = 0; k < 5; k++) begin
         if (k == stall_oe) return;
         push_acc(1'b1, 32'h40 + 2 * k, 16'hFFFF);
      end
      for (int p = 0; p < 4 && !stop; p++) begin
         for (int k = 0; k < 5; k++) push_acc(1'b1, 32'h20 + 2 * k, pats[p]);
         for (int k = 0; k < 5 && !stop; k++) begin
            push_acc(1'b0, 2 * k, 16'h0);
            if (p == fp && k == fw) stop = 1;
         end
      end
      for (int k = 0; k < 5; k++) push_acc(1'b1, 32'h40 + 2 * k, 16'h0000);
   endtask

   task automatic pulse_start_a();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
   endtask

   // Monitor DUT A until done_o, comparing every acknowledged access with the scoreboard.
   task automatic run_a(input int restart_at, output int max_run, output bit saw_done);
      int run_len = 0;
      acc_t e;
      max_run  = 0;
      saw_done = 0;
      for (int c = 0; c < 3000 && !saw_done; c++) begin
         @(negedge clk);
         start_a = (c == restart_at);
         if (a_if.wbm_cyc_o) run_len++;
         else begin
            if (run_len > max_run) max_run = run_len;
            run_len = 0;
         end
         if (a_if.wbm_cyc_o && a_if.wbm_stb_o && a_if.wbm_ack_i) begin
            if (exp_q.size() == 0) check("unexpected_access", {31'h0, a_if.wbm_we_o, a_if.wbm_adr_o}, 64'h0);
            else begin
               e = exp_q.pop_front();
               check("access", {15'h0, a_if.wbm_we_o, a_if.wbm_adr_o,
                                a_if.wbm_we_o ? a_if.wbm_dat_o : 16'h0},
                     {15'h0, e.we, e.adr, e.dat});
            end
         end
         if (done_a) saw_done = 1;
      end
      start_a = 1'b0;
      check("done_seen", 64'(saw_done), 64'd1);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int  max_run;
      bit  saw_done;
      bit  seen_cyc;
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_bus", {13'h0, a_if.wbm_cyc_o, a_if.wbm_stb_o, a_if.wbm_we_o,
                        a_if.wbm_adr_o, a_if.wbm_dat_o}, 64'h0);
      check("rst_status", {busy_a, done_a, pass_a, tmo_a, fw_a, fp_a}, 64'h0);
      @(negedge clk) rst_n = 1'b1;
      check("sel_const", 64'(a_if.wbm_sel_o), 64'h3);

      // Acks while idle must not start anything
      spur_ack = 1'b1;
      repeat (5) @(negedge clk);
      spur_ack = 1'b0;
      check("spur_ack_idle", {a_if.wbm_cyc_o, busy_a, done_a}, 64'h0);

      // GPIO_COUNT=72 with garbage in masked bits
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      saw_done = 0;
      for (int c = 0; c < 3000 && !saw_done; c++) begin
         @(negedge clk);
         if (done_b) saw_done = 1;
      end
      check("b_done_seen", 64'(saw_done), 64'd1);
      check("b_result", {pass_b, tmo_b, fw_b, fp_b}, {1'b1, 1'b0, 8'h0, 2'd0});

      // Clean run with a second start mid-run (must be ignored)
      build_expected(-1, -1, -1);
      pulse_start_a();
      check("busy_after_start", {busy_a, pass_a}, 64'b10);
      run_a(40, max_run, saw_done);
      check("pass_result", {pass_a, tmo_a, fw_a, fp_a}, {1'b1, 1'b0, 8'h0, 2'd0});
      check("access_len", 64'(max_run), 64'd2);
      @(negedge clk);
      check("done_one_cycle", {done_a, busy_a}, 64'h0);

      // Stuck-at-0 on input word 2 bit 0
      stuck = 1'b1;
      build_expected(2, 1, -1);
      pulse_start_a();
      check("pass_cleared_on_start", 64'(pass_a), 64'd0);
      run_a(-1, max_run, saw_done);
      check("stuck_result", {pass_a, tmo_a, fw_a, fp_a}, {1'b0, 1'b0, 8'd2, 2'd1});
      stuck = 1'b0;

      // Third OE write never acknowledged
      noack = 1'b1;
      build_expected(-1, -1, 2);
      pulse_start_a();
      run_a(-1, max_run, saw_done);
      check("timeout_len", 64'(max_run), 64'd256);
      check("timeout_result", {pass_a, tmo_a, fw_a, fp_a}, {1'b0, 1'b1, 8'h0, 2'd0});
      noack = 1'b0;

      // Reset during a write
      pulse_start_a();
      seen_cyc = 0;
      for (int c = 0; c < 200 && !seen_cyc; c++) begin
         @(negedge clk);
         if (a_if.wbm_cyc_o && a_if.wbm_we_o) seen_cyc = 1;
      end
      check("write_seen", 64'(seen_cyc), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_bus", {13'h0, a_if.wbm_cyc_o, a_if.wbm_stb_o, a_if.wbm_we_o,
                            a_if.wbm_adr_o, a_if.wbm_dat_o}, 64'h0);
      check("rst_mid_status", {busy_a, done_a, pass_a, tmo_a, fw_a, fp_a}, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen_cyc = 0;
      repeat (20) begin
         @(negedge clk);
         if (a_if.wbm_cyc_o || busy_a) seen_cyc = 1;
      end
      check("idle_after_reset", 64'(seen_cyc), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gpio_test_seq.md
GPIO_TEST_SEQ -- requirements
Module: gpio_test_seq

Interface
REQ-001 Parameter GPIO_COUNT, default 80, number of GPIO lines exercised; word count W = ceil(GPIO_COUNT/16).
REQ-002 Parameter BASE_ADR, default 32'h0, byte base address of the target GPIO test slave.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles a bus access may wait for ack.
REQ-004 wb_clk_i  in  1  single clock for all logic.
REQ-005 wb_rst_n_i  in  1  reset, asynchronous assert, active-low; the block has one clock and an asynchronous active-low reset.
REQ-006 start_i  in  1  one-cycle pulse that launches a test run; ignored while busy_o=1.
REQ-007 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master cycle, strobe, write enable.
REQ-008 wbm_sel_o  out  2  byte selects, constant 2'b11.
REQ-009 wbm_adr_o  out  32  byte address.
REQ-010 wbm_dat_o  out  16  write data.
REQ-011 wbm_dat_i  in  16  read data.
REQ-012 wbm_ack_i  in  1  slave acknowledge.
REQ-013 busy_o  out  1  run in progress.
REQ-014 done_o  out  1  one-cycle pulse at run end.
REQ-015 pass_o  out  1  last run passed; valid from done_o until next start.
REQ-016 timeout_o  out  1  last run aborted by bus timeout.
REQ-017 fail_word_o  out  8  word index of first mismatch; fail_pat_o  out  2  pattern index of first mismatch.

Function
REQ-018 Register map relative to BASE_ADR: input data words at 0x00+2k, output data at 0x20+2k, output enables at 0x40+2k, k = 0..W-1.
REQ-019 Patterns indexed 0..3 SHALL be 16'h0000, 16'hFFFF, 16'h5555, 16'hAAAA.
REQ-020 States: IDLE, OE_ON, WR_DOUT, RD_DIN, OE_OFF, FINISH.
REQ-021 IDLE -> OE_ON on start_i; clears pass_o, timeout_o, fail_word_o, fail_pat_o; busy_o=1 from the next cycle.
REQ-022 OE_ON writes 16'hFFFF to every OE word k=0..W-1, then -> WR_DOUT with pattern 0.
REQ-023 WR_DOUT writes the current pattern to every data-out word, then -> RD_DIN.
REQ-024 RD_DIN reads every data-in word and compares with the pattern under mask; last word mask = low (GPIO_COUNT mod 16) bits, all 16 bits if remainder is 0; other words full mask.
REQ-025 First mismatch latches fail_word_o=k, fail_pat_o=pattern index, skips remaining reads and patterns, -> OE_OFF.
REQ-026 After pattern 3 reads with no mismatch -> OE_OFF with pass flag set.
REQ-027 OE_OFF writes 16'h0000 to every OE word, then -> FINISH.
REQ-028 FINISH pulses done_o for one cycle, drives pass_o, clears busy_o, -> IDLE.
REQ-029 Each access: cyc/stb/we/adr/dat asserted together and held stable until the cycle wbm_ack_i=1 is sampled; cyc/stb deasserted for at least one cycle before the next access; read data captured on the ack cycle.
REQ-030 wbm_ack_i while cyc=0 SHALL be ignored.
REQ-031 Timeout counter resets at each access start; if it reaches TIMEOUT without ack, drop cyc/stb next cycle, set timeout_o=1, pass_o=0, skip OE_OFF, -> FINISH.
REQ-032 start_i during busy SHALL have no effect.

Reset
REQ-033 While wb_rst_n_i=0: state IDLE, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0, busy_o=done_o=pass_o=timeout_o=0, fail_word_o=0, fail_pat_o=0, counters 0.
REQ-034 Reset asserted mid-access SHALL drop cyc/stb immediately (asynchronously); after release no access until a new start_i.

Verification
REQ-035 GPIO_COUNT=80, loopback slave, ack after 1 cycle, start -> 5 OE writes FFFF at 0x40..0x48, then 4x(5 writes to 0x20..0x28, 5 reads 0x00..0x08), 5 OE writes 0000; done_o pulse, pass_o=1, timeout_o=0.
REQ-036 Slave forces input word 2 bit 0 stuck-at-0 -> pattern 0 passes, mismatch at pattern 1: fail_word_o=2, fail_pat_o=1, pass_o=0, OE_OFF writes still issued, no further reads.
REQ-037 GPIO_COUNT=72, input word 4 bits 15:8 return garbage, others loop back -> pass_o=1 (masked).
REQ-038 Slave never acks on the third OE write, TIMEOUT=255 -> cyc drops 256 cycles after stb assert, timeout_o=1, pass_o=0, done_o pulse, no OE_OFF writes.
REQ-039 start_i pulsed again mid-run and wb_rst_n_i pulsed low during a write -> second start ignored; reset clears all outputs to REQ-033 values with cyc=0 in the same cycle.
